// File: rtl/spatz_vlsu_tcdm_adapter_pkg.sv
// Shared types for the VLSU-to-TCDM memory port adapter.
// Element width, id width and X-interface field types.
package spatz_vlsu_tcdm_adapter_pkg;

    localparam int unsigned ELEN                = 32;
    localparam int unsigned N_OUTSTANDING_LOADS = 8;
    localparam int unsigned X_ID_WIDTH          = $clog2(N_OUTSTANDING_LOADS);
    localparam int unsigned X_ADDR_WIDTH        = 32;

    typedef logic [X_ID_WIDTH-1:0]   x_id_t;
    typedef logic [X_ADDR_WIDTH-1:0] x_addr_t;
    typedef logic [ELEN-1:0]         x_data_t;
    typedef logic [ELEN/8-1:0]       x_strb_t;

endpackage

// File: rtl/spatz_vlsu_tcdm_adapter_fifo.sv
// In-order FIFO of in-flight transaction tags.
// No fall-through: full/empty reflect registered state only.
module spatz_vlsu_tcdm_adapter_fifo
    import spatz_vlsu_tcdm_adapter_pkg::*;
#(
    parameter int unsigned Width = 5,
    parameter int unsigned Depth = 8,
    localparam int unsigned PtrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    input  logic             i_pop,
    output logic [Width-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [PtrW:0]    o_usage
);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [PtrW:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == (PtrW+1)'(Depth));
    assign o_empty = (r_cnt == '0);
    assign o_usage = r_cnt;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointer and fill-level bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

    // Tag storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/spatz_vlsu_tcdm_adapter.sv
// VLSU memory port to TCDM adapter.
// Zero-latency request path, registered tagged responses.
module spatz_vlsu_tcdm_adapter
    import spatz_vlsu_tcdm_adapter_pkg::*;
#(
    parameter int unsigned AddrWidth     = X_ADDR_WIDTH,
    parameter int unsigned DataWidth     = ELEN,
    parameter int unsigned IdWidth       = X_ID_WIDTH,
    parameter int unsigned NrOutstanding = N_OUTSTANDING_LOADS,
    localparam int unsigned CntW = $clog2(NrOutstanding) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   x_mem_valid_i,
    output logic                   x_mem_ready_o,
    input  logic [IdWidth-1:0]     x_mem_id_i,
    input  logic [AddrWidth-1:0]   x_mem_addr_i,
    input  logic                   x_mem_we_i,
    input  logic [DataWidth/8-1:0] x_mem_strb_i,
    input  logic [DataWidth-1:0]   x_mem_wdata_i,
    input  logic                   x_mem_last_i,
    output logic                   x_mem_result_valid_o,
    output logic [IdWidth-1:0]     x_mem_result_id_o,
    output logic [DataWidth-1:0]   x_mem_result_rdata_o,
    output logic                   x_mem_done_o,
    output logic                   tcdm_req_o,
    input  logic                   tcdm_gnt_i,
    output logic [AddrWidth-1:0]   tcdm_add_o,
    output logic                   tcdm_wen_o,
    output logic [DataWidth/8-1:0] tcdm_be_o,
    output logic [DataWidth-1:0]   tcdm_wdata_o,
    input  logic                   tcdm_rvalid_i,
    input  logic [DataWidth-1:0]   tcdm_rdata_i,
    output logic [CntW-1:0]        outstanding_o,
    output logic                   idle_o,
    output logic                   err_o
);

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic               we;
        logic               last;
    } entry_t;

    localparam int unsigned EntryW = $bits(entry_t);

    entry_t              w_push_e;
    entry_t              w_head;
    logic [EntryW-1:0]   w_head_bits;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_spurious;

    logic                r_res_valid;
    logic [IdWidth-1:0]  r_res_id;
    logic [DataWidth-1:0] r_res_rdata;
    logic                r_done;
    logic                r_err;

    assign tcdm_req_o    = x_mem_valid_i & ~w_full;
    assign x_mem_ready_o = tcdm_req_o & tcdm_gnt_i;
    assign tcdm_add_o    = x_mem_addr_i;
    assign tcdm_wen_o    = x_mem_we_i;
    assign tcdm_be_o     = x_mem_we_i ? x_mem_strb_i : '1;
    assign tcdm_wdata_o  = x_mem_wdata_i;

    assign w_push_e   = '{id: x_mem_id_i, we: x_mem_we_i, last: x_mem_last_i};
    assign w_head     = entry_t'(w_head_bits);
    assign w_pop      = tcdm_rvalid_i & ~w_empty;
    assign w_spurious = tcdm_rvalid_i & w_empty;

    spatz_vlsu_tcdm_adapter_fifo #(
        .Width (EntryW),
        .Depth (NrOutstanding)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (x_mem_ready_o),
        .i_data  (w_push_e),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_usage (outstanding_o)
    );

    // Turn a popped response into a tagged result and completion pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_rdata <= '0;
            r_done      <= 1'b0;
        end else begin
            r_res_valid <= w_pop & ~w_head.we;
            r_done      <= w_pop & w_head.last;
            if (w_pop && !w_head.we) begin
                r_res_id    <= w_head.id;
                r_res_rdata <= tcdm_rdata_i;
            end
        end
    end

    // Sticky flag for a response with nothing in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_err <= 1'b0;
        else if (w_spurious) r_err <= 1'b1;
    end

    assign x_mem_result_valid_o = r_res_valid;
    assign x_mem_result_id_o    = r_res_id;
    assign x_mem_result_rdata_o = r_res_rdata;
    assign x_mem_done_o         = r_done;
    assign err_o                = r_err;
    assign idle_o               = w_empty & ~r_res_valid;

endmodule

// File: tb/tb_spatz_vlsu_tcdm_adapter.sv
// Bench for the VLSU-to-TCDM adapter.
// Directed table, corner sequences and random traffic vs a queue model.
module tb_spatz_vlsu_tcdm_adapter;

    localparam int NOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        x_mem_valid;
    logic        x_mem_ready;
    logic [2:0]  x_mem_id;
    logic [31:0] x_mem_addr;
    logic        x_mem_we;
    logic [3:0]  x_mem_strb;
    logic [31:0] x_mem_wdata;
    logic        x_mem_last;
    logic        res_valid;
    logic [2:0]  res_id;
    logic [31:0] res_rdata;
    logic        done;
    logic        tcdm_req;
    logic        tcdm_gnt;
    logic [31:0] tcdm_add;
    logic        tcdm_wen;
    logic [3:0]  tcdm_be;
    logic [31:0] tcdm_wdata;
    logic        tcdm_rvalid;
    logic [31:0] tcdm_rdata;
    logic [3:0]  outstanding;
    logic        idle;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spatz_vlsu_tcdm_adapter dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .x_mem_valid_i        (x_mem_valid),
        .x_mem_ready_o        (x_mem_ready),
        .x_mem_id_i           (x_mem_id),
        .x_mem_addr_i         (x_mem_addr),
        .x_mem_we_i           (x_mem_we),
        .x_mem_strb_i         (x_mem_strb),
        .x_mem_wdata_i        (x_mem_wdata),
        .x_mem_last_i         (x_mem_last),
        .x_mem_result_valid_o (res_valid),
        .x_mem_result_id_o    (res_id),
        .x_mem_result_rdata_o (res_rdata),
        .x_mem_done_o         (done),
        .tcdm_req_o           (tcdm_req),
        .tcdm_gnt_i           (tcdm_gnt),
        .tcdm_add_o           (tcdm_add),
        .tcdm_wen_o           (tcdm_wen),
        .tcdm_be_o            (tcdm_be),
        .tcdm_wdata_o         (tcdm_wdata),
        .tcdm_rvalid_i        (tcdm_rvalid),
        .tcdm_rdata_i         (tcdm_rdata),
        .outstanding_o        (outstanding),
        .idle_o               (idle),
        .err_o                (err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of in-flight tags plus expected result registers.
    typedef struct {
        logic [2:0] id;
        logic       we;
        logic       last;
    } ent_t;

    ent_t        q[$];
    logic        m_rv;
    logic [2:0]  m_rid;
    logic [31:0] m_rdata;
    logic        m_done;
    logic        m_err;
    logic [2:0]  got_ids[$];

    task automatic drive(input logic v, input logic [2:0] id, input logic [31:0] a,
                         input logic we, input logic [3:0] sb, input logic [31:0] wd,
                         input logic l, input logic g, input logic rv, input logic [31:0] rd);
        x_mem_valid = v;  x_mem_id = id;   x_mem_addr = a;
        x_mem_we    = we; x_mem_strb = sb; x_mem_wdata = wd;
        x_mem_last  = l;  tcdm_gnt = g;    tcdm_rvalid = rv;
        tcdm_rdata  = rd;
    endtask

    task automatic reset_dut();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_rv",    res_valid,   0);
        chk("rst_done",  done,        0);
        chk("rst_err",   err,         0);
        chk("rst_out",   outstanding, 0);
        chk("rst_idle",  idle,        1);
        chk("rst_rid",   res_id,      0);
        chk("rst_rdata", res_rdata,   0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        m_rv = 0; m_rid = 0; m_rdata = 0; m_done = 0; m_err = 0;
    endtask

    task automatic cyc(input logic v, input logic [2:0] id, input logic [31:0] a,
                       input logic we, input logic [3:0] sb, input logic [31:0] wd,
                       input logic l, input logic g, input logic rv, input logic [31:0] rd);
        logic er;
        ent_t h;
        drive(v, id, a, we, sb, wd, l, g, rv, rd);
        #1;
        er = v && (q.size() < NOUT);
        chk("req",   tcdm_req,    er);
        chk("ready", x_mem_ready, er && g);
        chk("be",    tcdm_be,     we ? sb : 4'hF);
        chk("wen",   tcdm_wen,    we);
        chk("add",   tcdm_add,    a);
        m_rv = 0;
        m_done = 0;
        if (rv) begin
            if (q.size() > 0) begin
                h = q.pop_front();
                m_rv = !h.we;
                m_done = h.last;
                if (!h.we) begin
                    m_rid = h.id;
                    m_rdata = rd;
                end
            end else begin
                m_err = 1;
            end
        end
        if (er && g) q.push_back('{id, we, l});
        @(posedge clk);
        #1;
        chk("res_valid", res_valid,   m_rv);
        chk("res_id",    res_id,      m_rid);
        chk("res_rdata", res_rdata,   m_rdata);
        chk("done",      done,        m_done);
        chk("err",       err,         m_err);
        chk("out",       outstanding, q.size());
        chk("idle",      idle,        (q.size() == 0) && !m_rv);
        if (res_valid === 1'b1) got_ids.push_back(res_id);
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * NOUT && q.size() > 0; k++)
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA000_0000 + k);
        idle_cyc();
    endtask

    typedef struct {
        logic        v;
        logic [2:0]  id;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic        last;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        e_ready;
        logic        e_req;
        logic [3:0]  e_be;
        logic        e_wen;
        logic        e_rv;
        logic [2:0]  e_rid;
        logic [31:0] e_rdata;
        logic        e_done;
        logic [3:0]  e_out;
        logic        e_idle;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1, 2, 'h100, 0, 0, 0, 0, 0, 0, 0,
                   0, 1, 'hF, 0, 0, 0, 0, 0, 0, 1};
        tbl[1] = '{1, 2, 'h100, 0, 0, 0, 0, 1, 0, 0,
                   1, 1, 'hF, 0, 0, 0, 0, 0, 1, 0};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 'hF, 0, 0, 0, 0, 0, 1, 0};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF,
                   0, 0, 'hF, 0, 1, 2, 'hDEADBEEF, 0, 0, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 'hF, 0, 0, 2, 'hDEADBEEF, 0, 0, 1};
        tbl[5] = '{1, 5, 'h204, 1, 'h3, 'h12345678, 1, 1, 0, 0,
                   1, 1, 'h3, 1, 0, 2, 'hDEADBEEF, 0, 1, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 'hCAFE0000,
                   0, 0, 'hF, 0, 0, 2, 'hDEADBEEF, 1, 0, 1};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 'hF, 0, 0, 2, 'hDEADBEEF, 0, 0, 1};

        reset_dut();

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].id, tbl[i].addr, tbl[i].we, tbl[i].strb,
                  tbl[i].wd, tbl[i].last, tbl[i].gnt, tbl[i].rv, tbl[i].rd);
            #1;
            chk($sformatf("t%0d_ready", i), x_mem_ready, tbl[i].e_ready);
            chk($sformatf("t%0d_req", i),   tcdm_req,    tbl[i].e_req);
            chk($sformatf("t%0d_be", i),    tcdm_be,     tbl[i].e_be);
            chk($sformatf("t%0d_wen", i),   tcdm_wen,    tbl[i].e_wen);
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_rv", i),    res_valid,   tbl[i].e_rv);
            chk($sformatf("t%0d_rid", i),   res_id,      tbl[i].e_rid);
            chk($sformatf("t%0d_rdata", i), res_rdata,   tbl[i].e_rdata);
            chk($sformatf("t%0d_done", i),  done,        tbl[i].e_done);
            chk($sformatf("t%0d_out", i),   outstanding, tbl[i].e_out);
            chk($sformatf("t%0d_idle", i),  idle,        tbl[i].e_idle);
        end

        reset_dut();

        // Fill to capacity, then a full cycle blocks even with a response.
        for (int i = 0; i < NOUT; i++)
            cyc(1, i[2:0], 32'h1000 + 4 * i, 0, 0, 0, 0, 1, 0, 0);
        chk("full_out8", outstanding, 8);
        cyc(1, 0, 32'h2000, 0, 0, 0, 0, 1, 0, 0);
        chk("full_noready", x_mem_ready, 0);
        cyc(1, 1, 32'h2004, 0, 0, 0, 0, 1, 1, 32'h1111_0000);
        chk("full_pop_out7", outstanding, 7);
        cyc(1, 1, 32'h2004, 0, 0, 0, 0, 1, 0, 0);
        chk("refill_out8", outstanding, 8);
        drain();

        // Load/store/load with grant stalls; results only for loads, in order.
        got_ids.delete();
        cyc(1, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'h300, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 2, 32'h304, 1, 4'hC, 32'h55AA, 0, 0, 0, 0);
        cyc(1, 2, 32'h304, 1, 4'hC, 32'h55AA, 0, 1, 0, 0);
        cyc(1, 3, 32'h308, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 3, 32'h308, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 3, 32'h308, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 3, 32'h308, 0, 0, 0, 1, 1, 1, 32'h0101_0101);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0202_0202);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0303_0303);
        idle_cyc();
        chk("mix_nres", got_ids.size(), 2);
        if (got_ids.size() == 2) begin
            chk("mix_id0", got_ids[0], 1);
            chk("mix_id1", got_ids[1], 3);
        end
        chk("mix_rdata", res_rdata, 32'h0303_0303);

        // Simultaneous push and pop at four in flight.
        for (int i = 0; i < 4; i++)
            cyc(1, i[2:0], 32'h400 + 4 * i, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 7, 32'h410, 0, 0, 0, 0, 1, 1, 32'hBEEF_0004);
        chk("pp_out4", outstanding, 4);
        chk("pp_rv", res_valid, 1);
        chk("pp_rid", res_id, 0);
        drain();

        // Spurious response after reset.
        reset_dut();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h9999_9999);
        chk("sp_err", err, 1);
        chk("sp_rv", res_valid, 0);
        idle_cyc();
        chk("sp_sticky", err, 1);
        reset_dut();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic v, we, l, g, rv;
            v  = ($urandom_range(0, 9) < 7);
            we = $urandom_range(0, 1);
            l  = ($urandom_range(0, 3) == 0);
            g  = ($urandom_range(0, 9) < 6);
            rv = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            cyc(v, 3'($urandom), {$urandom} & 32'hFFFF_FFFC, we, 4'($urandom),
                $urandom, l, g, rv, $urandom);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
